// File: rtl/even_operand_fwd.sv
// Register-fetch/forward stage feeding the even-pipe SP/multiply unit.
// Per-operand bypass muxing from FP6, FP7 and the RF write port, nop bubbles on stall/flush.

module even_operand_fwd_sel #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7
) (
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic              wb_vld_i,
  input  logic [DATA_W-1:0] int_data_i,
  input  logic [ADDR_W-1:0] int_addr_i,
  input  logic              int_vld_i,
  input  logic [DATA_W-1:0] rfw_data_i,
  input  logic [ADDR_W-1:0] rfw_addr_i,
  input  logic              rfw_vld_i,
  output logic [DATA_W-1:0] data_o,
  output logic              hit_o
);
  logic wb_hit, int_hit, rfw_hit;

  assign wb_hit  = wb_vld_i  && (wb_addr_i  == src_addr_i);
  assign int_hit = int_vld_i && (int_addr_i == src_addr_i);
  assign rfw_hit = rfw_vld_i && (rfw_addr_i == src_addr_i);

  // FP6 holds the youngest result, so it outranks FP7 and the RF write port.
  always_comb begin
    data_o = rf_data_i;
    hit_o  = 1'b1;
    if (wb_hit)       data_o = wb_data_i;
    else if (int_hit) data_o = int_data_i;
    else if (rfw_hit) data_o = rfw_data_i;
    else              hit_o  = 1'b0;
  end
endmodule

module even_operand_fwd #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       op_in,
  input  logic [2:0]        format_in,
  input  logic [17:0]       imm_in,
  input  logic [ADDR_W-1:0] rt_addr_in,
  input  logic              reg_write_in,
  input  logic [ADDR_W-1:0] ra_addr_in,
  input  logic [ADDR_W-1:0] rb_addr_in,
  input  logic [ADDR_W-1:0] rc_addr_in,
  input  logic [DATA_W-1:0] ra_rf,
  input  logic [DATA_W-1:0] rb_rf,
  input  logic [DATA_W-1:0] rc_rf,
  input  logic [DATA_W-1:0] rt_wb,
  input  logic [ADDR_W-1:0] rt_addr_wb,
  input  logic              reg_write_wb,
  input  logic [DATA_W-1:0] rt_int,
  input  logic [ADDR_W-1:0] rt_addr_int,
  input  logic              reg_write_int,
  input  logic [DATA_W-1:0] rt_rf_wr,
  input  logic [ADDR_W-1:0] rt_addr_rf_wr,
  input  logic              reg_write_rf_wr,
  input  logic              stall,
  input  logic              branch_taken,
  output logic [10:0]       op,
  output logic [2:0]        format,
  output logic [17:0]       imm,
  output logic [ADDR_W-1:0] rt_addr,
  output logic              reg_write,
  output logic [DATA_W-1:0] ra,
  output logic [DATA_W-1:0] rb,
  output logic [DATA_W-1:0] rc,
  output logic [15:0]       fwd_count
);
  localparam int NUM_OPS = 3;

  logic [NUM_OPS-1:0][ADDR_W-1:0] src_addr;
  logic [NUM_OPS-1:0][DATA_W-1:0] rf_data;
  logic [NUM_OPS-1:0][DATA_W-1:0] fwd_data;
  logic [NUM_OPS-1:0]             fwd_hit;

  assign src_addr = {rc_addr_in, rb_addr_in, ra_addr_in};
  assign rf_data  = {rc_rf, rb_rf, ra_rf};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_sel
    even_operand_fwd_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_sel (
      .src_addr_i (src_addr[g]),
      .rf_data_i  (rf_data[g]),
      .wb_data_i  (rt_wb),
      .wb_addr_i  (rt_addr_wb),
      .wb_vld_i   (reg_write_wb),
      .int_data_i (rt_int),
      .int_addr_i (rt_addr_int),
      .int_vld_i  (reg_write_int),
      .rfw_data_i (rt_rf_wr),
      .rfw_addr_i (rt_addr_rf_wr),
      .rfw_vld_i  (reg_write_rf_wr),
      .data_o     (fwd_data[g]),
      .hit_o      (fwd_hit[g])
    );
  end

  logic              bubble, dec_nop;
  logic [1:0]        hit_cnt;
  logic [16:0]       cnt_sum;

  logic [10:0]       op_q, op_d;
  logic [2:0]        format_q, format_d;
  logic [17:0]       imm_q, imm_d;
  logic [ADDR_W-1:0] rt_addr_q, rt_addr_d;
  logic              reg_write_q, reg_write_d;
  logic [DATA_W-1:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [15:0]       cnt_q, cnt_d;

  assign bubble  = stall | branch_taken;
  // Opcode bits 0..9 use MSB-first numbering, i.e. op_in[10:1].
  assign dec_nop = (format_in == 3'd0) && (op_in[10:1] == 10'd0);
  assign hit_cnt = 2'(fwd_hit[0]) + 2'(fwd_hit[1]) + 2'(fwd_hit[2]);
  assign cnt_sum = {1'b0, cnt_q} + 17'(hit_cnt);

  always_comb begin
    op_d        = op_in;
    format_d    = format_in;
    imm_d       = imm_in;
    rt_addr_d   = rt_addr_in;
    reg_write_d = reg_write_in & ~dec_nop;
    ra_d        = fwd_data[0];
    rb_d        = fwd_data[1];
    rc_d        = fwd_data[2];
    cnt_d       = cnt_q;
    if (bubble) begin
      op_d        = '0;
      format_d    = '0;
      imm_d       = '0;
      rt_addr_d   = '0;
      reg_write_d = 1'b0;
      ra_d        = '0;
      rb_d        = '0;
      rc_d        = '0;
    end else if (!dec_nop) begin
      cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= '0;
      format_q    <= '0;
      imm_q       <= '0;
      rt_addr_q   <= '0;
      reg_write_q <= 1'b0;
      ra_q        <= '0;
      rb_q        <= '0;
      rc_q        <= '0;
      cnt_q       <= '0;
    end else begin
      op_q        <= op_d;
      format_q    <= format_d;
      imm_q       <= imm_d;
      rt_addr_q   <= rt_addr_d;
      reg_write_q <= reg_write_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      rc_q        <= rc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign op        = op_q;
  assign format    = format_q;
  assign imm       = imm_q;
  assign rt_addr   = rt_addr_q;
  assign reg_write = reg_write_q;
  assign ra        = ra_q;
  assign rb        = rb_q;
  assign rc        = rc_q;
  assign fwd_count = cnt_q;
endmodule

// File: tb/tb_even_operand_fwd.sv
// Directed bench for even_operand_fwd: reset, bypass priority, multi-operand, bubbles, nop, saturation.

module tb_even_operand_fwd;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 7;

  logic              clk, reset;
  logic [10:0]       op_in;
  logic [2:0]        format_in;
  logic [17:0]       imm_in;
  logic [ADDR_W-1:0] rt_addr_in, ra_addr_in, rb_addr_in, rc_addr_in;
  logic              reg_write_in;
  logic [DATA_W-1:0] ra_rf, rb_rf, rc_rf, rt_wb, rt_int, rt_rf_wr;
  logic [ADDR_W-1:0] rt_addr_wb, rt_addr_int, rt_addr_rf_wr;
  logic              reg_write_wb, reg_write_int, reg_write_rf_wr;
  logic              stall, branch_taken;
  logic [10:0]       op;
  logic [2:0]        format;
  logic [17:0]       imm;
  logic [ADDR_W-1:0] rt_addr;
  logic              reg_write;
  logic [DATA_W-1:0] ra, rb, rc;
  logic [15:0]       fwd_count;

  int checks = 0;
  int errors = 0;

  localparam logic [DATA_W-1:0] VA = {32'hAAAA_0001, 96'h1};
  localparam logic [DATA_W-1:0] VB = {32'hBBBB_0002, 96'h2};
  localparam logic [DATA_W-1:0] VC = {32'hCCCC_0003, 96'h3};
  localparam logic [DATA_W-1:0] VX = {32'h1111_2222, 96'h33};
  localparam logic [DATA_W-1:0] VY = {32'h4444_5555, 96'h66};
  localparam logic [10:0]       FA = 11'b01011000100;

  even_operand_fwd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .op_in(op_in), .format_in(format_in), .imm_in(imm_in),
    .rt_addr_in(rt_addr_in), .reg_write_in(reg_write_in),
    .ra_addr_in(ra_addr_in), .rb_addr_in(rb_addr_in), .rc_addr_in(rc_addr_in),
    .ra_rf(ra_rf), .rb_rf(rb_rf), .rc_rf(rc_rf),
    .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb), .reg_write_wb(reg_write_wb),
    .rt_int(rt_int), .rt_addr_int(rt_addr_int), .reg_write_int(reg_write_int),
    .rt_rf_wr(rt_rf_wr), .rt_addr_rf_wr(rt_addr_rf_wr), .reg_write_rf_wr(reg_write_rf_wr),
    .stall(stall), .branch_taken(branch_taken),
    .op(op), .format(format), .imm(imm), .rt_addr(rt_addr), .reg_write(reg_write),
    .ra(ra), .rb(rb), .rc(rc), .fwd_count(fwd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    op_in = 11'h004; format_in = 3'd1; imm_in = 18'h3;
    rt_addr_in = 7'd10; reg_write_in = 1'b1;
    ra_addr_in = 7'd5; rb_addr_in = 7'd6; rc_addr_in = 7'd7;
    ra_rf = 128'h1; rb_rf = 128'h2; rc_rf = 128'h3;
    rt_wb = VA; rt_addr_wb = 7'd0; reg_write_wb = 1'b0;
    rt_int = VB; rt_addr_int = 7'd0; reg_write_int = 1'b0;
    rt_rf_wr = VC; rt_addr_rf_wr = 7'd0; reg_write_rf_wr = 1'b0;
    stall = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    tick(); tick();
    #2 reset = 1'b0;
    tick();
    checks++; if (ra !== 128'h1) begin errors++; $display("FAIL reset_first_ra got %h want 1", ra); end
    checks++; if (rc !== 128'h3) begin errors++; $display("FAIL reset_first_rc got %h want 3", rc); end
    checks++; if (op !== 11'h004 || format !== 3'd1 || imm !== 18'h3 || rt_addr !== 7'd10 || reg_write !== 1'b1) begin
      errors++; $display("FAIL reset_first_ctl got op=%h fmt=%h imm=%h rt=%0d rw=%b", op, format, imm, rt_addr, reg_write); end
    checks++; if (fwd_count !== 16'd0) begin errors++; $display("FAIL reset_first_cnt got %0d want 0", fwd_count); end
    // put nonzero state in, then reset between edges
    reg_write_wb = 1'b1; rt_addr_wb = 7'd5;
    tick();
    checks++; if (ra !== VA || fwd_count !== 16'd1) begin errors++; $display("FAIL pre_reset_fwd got ra=%h cnt=%0d want %h 1", ra, fwd_count, VA); end
    #2 reset = 1'b1;
    #1;
    checks++; if (op !== 0 || format !== 0 || imm !== 0 || rt_addr !== 0 || reg_write !== 0 || ra !== 0 || rb !== 0 || rc !== 0 || fwd_count !== 0) begin
      errors++; $display("FAIL async_reset got op=%h ra=%h cnt=%0d want all 0", op, ra, fwd_count); end
    reset = 1'b0;
    set_idle();
  endtask

  task automatic test_priority();
    ra_addr_in = 7'd9; rb_addr_in = 7'd20; rc_addr_in = 7'd21;
    rt_addr_wb = 7'd9; rt_addr_int = 7'd9; rt_addr_rf_wr = 7'd9;
    reg_write_wb = 1'b1; reg_write_int = 1'b1; reg_write_rf_wr = 1'b1;
    tick();
    checks++; if (ra !== VA || rb !== 128'h2 || fwd_count !== 16'd1) begin errors++; $display("FAIL prio_fp6 got ra=%h rb=%h cnt=%0d want %h 2 1", ra, rb, fwd_count, VA); end
    reg_write_wb = 1'b0;
    tick();
    checks++; if (ra !== VB || fwd_count !== 16'd2) begin errors++; $display("FAIL prio_fp7 got ra=%h cnt=%0d want %h 2", ra, fwd_count, VB); end
    reg_write_int = 1'b0;
    tick();
    checks++; if (ra !== VC || fwd_count !== 16'd3) begin errors++; $display("FAIL prio_rfwr got ra=%h cnt=%0d want %h 3", ra, fwd_count, VC); end
    reg_write_rf_wr = 1'b0;
    tick();
    checks++; if (ra !== 128'h1 || fwd_count !== 16'd3) begin errors++; $display("FAIL prio_none got ra=%h cnt=%0d want 1 3", ra, fwd_count); end
    ra_addr_in = 7'd0; rt_addr_wb = 7'd0; reg_write_wb = 1'b1;
    tick();
    checks++; if (ra !== VA || fwd_count !== 16'd4) begin errors++; $display("FAIL addr_zero got ra=%h cnt=%0d want %h 4", ra, fwd_count, VA); end
    set_idle();
  endtask

  task automatic test_multi();
    ra_addr_in = 7'd3; rb_addr_in = 7'd4; rc_addr_in = 7'd3;
    rt_int = VX; rt_addr_int = 7'd3; reg_write_int = 1'b1;
    rt_rf_wr = VY; rt_addr_rf_wr = 7'd4; reg_write_rf_wr = 1'b1;
    tick();
    checks++; if (ra !== VX || rb !== VY || rc !== VX) begin errors++; $display("FAIL multi_ops got ra=%h rb=%h rc=%h", ra, rb, rc); end
    checks++; if (fwd_count !== 16'd7) begin errors++; $display("FAIL multi_cnt got %0d want 7", fwd_count); end
    set_idle();
  endtask

  task automatic test_invalid();
    ra_addr_in = 7'd3; rt_addr_wb = 7'd3; reg_write_wb = 1'b0;
    ra_rf = 128'h5A;
    tick();
    checks++; if (ra !== 128'h5A || fwd_count !== 16'd7) begin errors++; $display("FAIL invalid_match got ra=%h cnt=%0d want 5a 7", ra, fwd_count); end
    set_idle();
  endtask

  task automatic test_bubble();
    op_in = FA; format_in = 3'd0; imm_in = 18'h5; rt_addr_in = 7'd12; reg_write_in = 1'b1;
    ra_addr_in = 7'd3; rt_int = VX; rt_addr_int = 7'd3; reg_write_int = 1'b1;
    branch_taken = 1'b1;
    tick();
    checks++; if (op !== 0 || format !== 0 || imm !== 0 || rt_addr !== 0 || reg_write !== 0 || ra !== 0 || rb !== 0 || rc !== 0 || fwd_count !== 16'd7) begin
      errors++; $display("FAIL bubble_branch got op=%h ra=%h rw=%b cnt=%0d", op, ra, reg_write, fwd_count); end
    branch_taken = 1'b0; stall = 1'b1;
    tick();
    checks++; if (op !== 0 || imm !== 0 || rt_addr !== 0 || reg_write !== 0 || ra !== 0 || rb !== 0 || rc !== 0 || fwd_count !== 16'd7) begin
      errors++; $display("FAIL bubble_stall got op=%h ra=%h rw=%b cnt=%0d", op, ra, reg_write, fwd_count); end
    branch_taken = 1'b1;
    tick();
    checks++; if (op !== 0 || ra !== 0 || reg_write !== 0 || fwd_count !== 16'd7) begin
      errors++; $display("FAIL bubble_both got op=%h ra=%h cnt=%0d", op, ra, fwd_count); end
    stall = 1'b0; branch_taken = 1'b0;
    tick();
    checks++; if (op !== FA || format !== 3'd0 || imm !== 18'h5 || rt_addr !== 7'd12 || reg_write !== 1'b1) begin
      errors++; $display("FAIL bubble_release_ctl got op=%h fmt=%h imm=%h rt=%0d rw=%b", op, format, imm, rt_addr, reg_write); end
    checks++; if (ra !== VX || rb !== 128'h2 || fwd_count !== 16'd8) begin errors++; $display("FAIL bubble_release_ops got ra=%h rb=%h cnt=%0d", ra, rb, fwd_count); end
    set_idle();
  endtask

  task automatic test_nop();
    op_in = 11'h000; format_in = 3'd0; imm_in = 18'h7; rt_addr_in = 7'd13; reg_write_in = 1'b1;
    ra_addr_in = 7'd3; rt_int = VX; rt_addr_int = 7'd3; reg_write_int = 1'b1;
    tick();
    checks++; if (ra !== VX || reg_write !== 1'b0 || op !== 0 || imm !== 18'h7 || rt_addr !== 7'd13) begin
      errors++; $display("FAIL dec_nop got ra=%h rw=%b op=%h imm=%h rt=%0d", ra, reg_write, op, imm, rt_addr); end
    checks++; if (fwd_count !== 16'd8) begin errors++; $display("FAIL dec_nop_cnt got %0d want 8", fwd_count); end
    set_idle();
  endtask

  task automatic test_saturation();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    set_idle();
    ra_addr_in = 7'd3; rb_addr_in = 7'd3; rc_addr_in = 7'd3;
    rt_addr_wb = 7'd3; reg_write_wb = 1'b1;
    repeat (21844) tick();
    checks++; if (fwd_count !== 16'hFFFC) begin errors++; $display("FAIL sat_pre got %h want fffc", fwd_count); end
    tick();
    checks++; if (fwd_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h want ffff", fwd_count); end
    tick();
    checks++; if (fwd_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", fwd_count); end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_multi();
    test_invalid();
    test_bubble();
    test_nop();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/even_operand_fwd.md
Name: even_operand_fwd

Overview:
- Register-fetch/forward stage directly upstream of the even-pipe single-precision/multiply unit.
- Takes a decoded even-pipe instruction and raw register-file read data, and bypasses in-flight results from the FP6 writeback, FP7 integer writeback and the final RF write port.
- Registers the selected operands and control fields into the one-cycle pipeline register that drives the unit's op/format/rt_addr/ra/rb/rc/imm/reg_write inputs.
- Converts stalls and taken branches into nop bubbles.

Parameters:
- DATA_W, 128, operand and result width.
- ADDR_W, 7, register address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op_in  in  11  decoded opcode.
- format_in  in  3  instruction format.
- imm_in  in  18  immediate.
- rt_addr_in  in  ADDR_W  destination register.
- reg_write_in  in  1  instruction writes the register table.
- ra_addr_in, rb_addr_in, rc_addr_in  in  ADDR_W each  source register addresses.
- ra_rf, rb_rf, rc_rf  in  DATA_W each  register-file read data for the source addresses.
- rt_wb, rt_addr_wb, reg_write_wb  in  DATA_W/ADDR_W/1  FP6 writeback bypass.
- rt_int, rt_addr_int, reg_write_int  in  DATA_W/ADDR_W/1  FP7 integer writeback bypass.
- rt_rf_wr, rt_addr_rf_wr, reg_write_rf_wr  in  DATA_W/ADDR_W/1  value being written to the RF this cycle.
- stall  in  1  hazard stall; the upstream stage holds its instruction.
- branch_taken  in  1  flush the current instruction.
- op, format, imm, rt_addr, reg_write  out  11/3/18/ADDR_W/1  registered control to the execute unit.
- ra, rb, rc  out  DATA_W each  registered forwarded operands.
- fwd_count  out  16  saturating count of operand bypasses taken.

Behaviour:
- All outputs are registered; latency from inputs to outputs is 1 cycle.
- Asynchronous reset clears every output to 0. The resulting op=0, format=0 is a nop.
- Operand select is evaluated independently for each of ra, rb, rc, in priority order:
  - FP6 bypass, if reg_write_wb=1 and rt_addr_wb equals the source address.
  - FP7 bypass, if reg_write_int=1 and rt_addr_int matches.
  - RF write port, if reg_write_rf_wr=1 and rt_addr_rf_wr matches.
  - Otherwise the RF read data.
- Rationale for priority: FP6 holds the youngest in-flight result, so it wins over FP7 and the RF port.
- A source whose valid bit is 0 never forwards, even if the address matches.
- Address 0 is an ordinary register and gets no special case.
- Bubble insertion: when stall=1 or branch_taken=1 at a clock edge, load a nop:
  - op=0, format=0, imm=0, rt_addr=0, reg_write=0, ra=rb=rc=0.
  - fwd_count is not incremented for that cycle.
- branch_taken and stall asserted together: produce a single bubble, identical to either alone.
- Normal cycle: load the _in control fields unchanged plus the forwarded operands.
- Decode-side nop input (format_in=0, op_in[0:9]=0): pass through as-is, with reg_write forced to 0 and operands forwarded normally. fwd_count is not incremented.
- fwd_count: on a normal non-nop cycle, add the number of operands (0–3) selected from a bypass source. Saturate at 16'hFFFF with no wrap.
- Reset asserted mid-operation: all outputs clear immediately (asynchronously) and fwd_count returns to 0.
- The block holds no further state beyond the output register and fwd_count.

Test Plan:
- Reset: assert reset between edges → all outputs 0 immediately; after deassert, ra_rf=128'h1, addresses 5/6/7, no bypass valid → next edge ra=128'h1, fwd_count=0.
- Priority: ra_addr_in=9; rt_addr_wb=9 (value A), rt_addr_int=9 (value B), rt_addr_rf_wr=9 (value C), all valid → ra=A. Drop reg_write_wb → ra=B. Drop reg_write_int → ra=C.
- Multi-operand: ra/rb/rc addrs 3/4/3; FP7 writes 3 with X; RF port writes 4 with Y → ra=X, rb=Y, rc=X, fwd_count +3.
- Invalid match: rt_addr_wb=3 with reg_write_wb=0, ra_addr_in=3 → ra=ra_rf, fwd_count unchanged.
- Bubble: fa (format 0, op 11'b01011000100) with branch_taken=1 → outputs all 0. Repeat with stall=1 → same. Next cycle with stall low → fa issued with correct operands.
- Saturation: preload with 21845 cycles of 3 forwards → fwd_count=16'hFFFF; one more forwarding cycle → stays 16'hFFFF.
